// File: rtl/ifetch_pkg.sv
// Shared types and default sizing for the instruction fetch unit.
package ifetch_pkg;

    localparam int unsigned TAM_DEFAULT      = 8;
    localparam int unsigned PROG_LEN_DEFAULT = 6;

    typedef enum logic {
        FETCH = 1'b0,
        DONE  = 1'b1
    } ifetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Front-end fetch: owns the PC, reads the combinational instruction memory and
// presents one instruction per cycle to decode over a valid/ready handshake.
module instruction_fetch
    import ifetch_pkg::*;
#(
    parameter int unsigned tam      = TAM_DEFAULT,
    parameter int unsigned PROG_LEN = PROG_LEN_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    output logic [tam-1:0] outAddr,
    input  logic [tam-1:0] inInstr,
    output logic [tam-1:0] outInstr,
    output logic [tam-1:0] outPc,
    output logic           outValid,
    input  logic           inReady,
    input  logic           inBranch,
    input  logic [tam-1:0] inTarget,
    output logic           outDone
);

    ifetch_state_t  state;
    ifetch_state_t  state_next;
    logic [tam-1:0] pc;
    logic [tam-1:0] pc_next;
    logic [tam-1:0] instr_next;
    logic [tam-1:0] opc_next;
    logic           valid_next;
    logic           done_next;
    logic           slot_free;
    logic           pc_in_range;

    assign outAddr = pc;

    // Output register can take a new word when empty or being drained this edge.
    assign slot_free = !outValid || inReady;

    // Widened compare so PROG_LEN == 2^tam stays representable.
    assign pc_in_range = ({1'b0, pc} < (tam + 1)'(PROG_LEN));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: a redirect always re-enters FETCH; running off the program ends in DONE.
    always_comb begin
        state_next = state;
        if (inBranch) begin
            state_next = FETCH;
        end else if (state == FETCH && !pc_in_range && slot_free) begin
            state_next = DONE;
        end
    end

    // Datapath next values: branch flush, load, or drain of an accepted word.
    always_comb begin
        pc_next    = pc;
        instr_next = outInstr;
        opc_next   = outPc;
        valid_next = outValid;
        if (inBranch) begin
            pc_next    = inTarget;
            valid_next = 1'b0;
        end else if (state == FETCH && pc_in_range && slot_free) begin
            instr_next = inInstr;
            opc_next   = pc;
            valid_next = 1'b1;
            pc_next    = pc + tam'(1);
        end else if (outValid && inReady) begin
            valid_next = 1'b0;
        end
        done_next = (state_next == DONE);
    end

    // PC and IF/ID output register
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= '0;
            outInstr <= '0;
            outPc    <= '0;
            outValid <= 1'b0;
            outDone  <= 1'b0;
        end else begin
            pc       <= pc_next;
            outInstr <= instr_next;
            outPc    <= opc_next;
            outValid <= valid_next;
            outDone  <= done_next;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the fetch rules.
module tb_instruction_fetch;

    localparam int unsigned TAM = 8;
    localparam int unsigned PL  = 6;

    logic           clk = 1'b0;
    logic           reset;
    logic [TAM-1:0] outAddr;
    logic [TAM-1:0] inInstr;
    logic [TAM-1:0] outInstr;
    logic [TAM-1:0] outPc;
    logic           outValid;
    logic           inReady;
    logic           inBranch;
    logic [TAM-1:0] inTarget;
    logic           outDone;

    logic [TAM-1:0] mem [256];
    int             prog [PL] = '{3, 9, 6, 5, 15, 10};

    int checks   = 0;
    int failures = 0;

    // Model state
    int m_pc, m_instr, m_opc;
    bit m_valid, m_done;

    instruction_fetch #(.tam(TAM), .PROG_LEN(PL)) dut (
        .clk      (clk),
        .reset    (reset),
        .outAddr  (outAddr),
        .inInstr  (inInstr),
        .outInstr (outInstr),
        .outPc    (outPc),
        .outValid (outValid),
        .inReady  (inReady),
        .inBranch (inBranch),
        .inTarget (inTarget),
        .outDone  (outDone)
    );

    // Combinational instruction memory
    assign inInstr = mem[outAddr];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Effect of one clock edge under the given inputs, per the fetch rules.
    task automatic model_step(input bit r, input bit rdy, input bit br, input int tgt);
        if (r) begin
            m_pc = 0; m_instr = 0; m_opc = 0; m_valid = 0; m_done = 0;
        end else if (br) begin
            m_pc = tgt; m_valid = 0; m_done = 0;
        end else if (!m_done && (!m_valid || rdy)) begin
            if (m_pc < PL) begin
                m_instr = int'(mem[m_pc]);
                m_opc   = m_pc;
                m_valid = 1;
                m_pc    = (m_pc + 1) % 256;
            end else begin
                m_valid = 0;
                m_done  = 1;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit rdy, input bit br, input int tgt);
        reset    = r;
        inReady  = rdy;
        inBranch = br;
        inTarget = TAM'(tgt);
        model_step(r, rdy, br, tgt);
        @(posedge clk);
        #1;
        check("m_addr",  32'(outAddr),  32'(m_pc));
        check("m_valid", 32'(outValid), 32'(m_valid));
        check("m_instr", 32'(outInstr), 32'(m_instr));
        check("m_pc",    32'(outPc),    32'(m_opc));
        check("m_done",  32'(outDone),  32'(m_done));
    endtask

    task automatic expect_o(input string tag, input int v, input int instr, input int pc, input int done);
        check({tag, " valid"}, 32'(outValid), 32'(v));
        check({tag, " instr"}, 32'(outInstr), 32'(instr));
        check({tag, " pc"},    32'(outPc),    32'(pc));
        check({tag, " done"},  32'(outDone),  32'(done));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = TAM'($urandom);
        for (int i = 0; i < int'(PL); i++) mem[i] = TAM'(prog[i]);
        reset = 1'b1; inReady = 1'b0; inBranch = 1'b0; inTarget = '0;

        // 1: full stream then done
        cyc(1, 1, 0, 0);
        expect_o("t1 rst", 0, 0, 0, 0);
        check("t1 rst addr", 32'(outAddr), 32'd0);
        for (int i = 0; i < int'(PL); i++) begin
            cyc(0, 1, 0, 0);
            expect_o("t1 seq", 1, prog[i], i, 0);
        end
        cyc(0, 1, 0, 0);
        expect_o("t1 end", 0, 10, 5, 1);

        // 2: backpressure while 9 is presented
        cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        expect_o("t2 pre", 1, 9, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0);
            expect_o("t2 hold", 1, 9, 1, 0);
            check("t2 hold addr", 32'(outAddr), 32'd2);
        end
        for (int i = 2; i < int'(PL); i++) begin
            cyc(0, 1, 0, 0);
            expect_o("t2 seq", 1, prog[i], i, 0);
        end
        cyc(0, 1, 0, 0);
        expect_o("t2 end", 0, 10, 5, 1);

        // 3: branch to 4 while 6 transfers
        cyc(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
        expect_o("t3 pre", 1, 6, 2, 0);
        cyc(0, 1, 1, 4);
        expect_o("t3 bubble", 0, 6, 2, 0);
        cyc(0, 1, 0, 0);
        expect_o("t3 a", 1, 15, 4, 0);
        cyc(0, 1, 0, 0);
        expect_o("t3 b", 1, 10, 5, 0);
        cyc(0, 1, 0, 0);
        expect_o("t3 end", 0, 10, 5, 1);

        // 4: branch out of DONE to 1
        cyc(0, 1, 1, 1);
        expect_o("t4 exit", 0, 10, 5, 0);
        for (int i = 1; i < int'(PL); i++) begin
            cyc(0, 1, 0, 0);
            expect_o("t4 seq", 1, prog[i], i, 0);
        end
        cyc(0, 1, 0, 0);
        expect_o("t4 end", 0, 10, 5, 1);

        // 5: out-of-range target
        cyc(0, 1, 1, 7);
        expect_o("t5 br", 0, 10, 5, 0);
        check("t5 addr", 32'(outAddr), 32'd7);
        cyc(0, 1, 0, 0);
        expect_o("t5 done", 0, 10, 5, 1);

        // 6: mid-stream reset
        cyc(1, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
        expect_o("t6 pre", 1, 5, 3, 0);
        cyc(1, 1, 0, 0);
        expect_o("t6 rst", 0, 0, 0, 0);
        check("t6 rst addr", 32'(outAddr), 32'd0);
        cyc(0, 1, 0, 0);
        expect_o("t6 restart", 1, 3, 0, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 49) == 0,
                $urandom_range(0, 9) < 7,
                $urandom_range(0, 9) == 0,
                int'($urandom_range(0, 9)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
